// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Pipeline control unit for a five-stage Y86 pipeline
//               (F, D, E, M, W). It watches decode, execute and writeback
//               state and issues stall and bubble controls to the F, D and E
//               pipeline registers. It also sequences the ret drain, latches
//               processor halt, and keeps saturating performance counters.
//
// Parameters  : CNT_W       - width of each performance counter
//               RET_BUBBLES - D-bubble cycles per ret (counting the ret's own
//                             decode cycle); the ret counter is 2 bits wide,
//                             so the usable range is 1..4
//
// Ports       : clk        in   pipeline clock, state updates on posedge
//               rst_n      in   asynchronous active-low reset
//               Dicode     in   icode of the instruction in decode
//               dsrcA      in   decode source A register (0xF = none)
//               dsrcB      in   decode source B register (0xF = none)
//               Eicode     in   icode in execute
//               EdstM      in   execute-stage dstM (0xF = none)
//               ecnd       in   condition result computed in execute
//               Wicode     in   icode in writeback
//               F_stall    out  hold the fetch PC register
//               D_stall    out  hold the decode pipeline register
//               D_bubble   out  load a nop into the decode register
//               E_bubble   out  load a nop into the execute register
//               halted     out  processor has retired a halt
//               ret_busy   out  ret drain in progress
//               stall_cnt  out  cycles lost to load-use stalls
//               bubble_cnt out  cycles lost to ret drains and mispredicts
//
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int RET_BUBBLES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       Dicode,
  input  logic [3:0]       dsrcA,
  input  logic [3:0]       dsrcB,
  input  logic [3:0]       Eicode,
  input  logic [3:0]       EdstM,
  input  logic             ecnd,
  input  logic [3:0]       Wicode,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             halted,
  output logic             ret_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [3:0] C_ICODE_HALT   = 4'h0;
  localparam logic [3:0] C_ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] C_ICODE_JXX    = 4'h7;
  localparam logic [3:0] C_ICODE_RET    = 4'h9;
  localparam logic [3:0] C_ICODE_POPQ   = 4'hB;
  localparam logic [3:0] C_REG_NONE     = 4'hF;

  // The ret's own RUN cycle is the first bubble, so the drain state only
  // has to cover the remaining RET_BUBBLES-1 cycles.
  localparam logic [1:0]       C_RET_LOAD = 2'(RET_BUBBLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_RET_WAIT = 2'd1,
    S_HALTED   = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t           r_state;
  logic [1:0]       r_ret_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  // --------------------------------------------------------------------------
  // Hazard detection and control decode
  // --------------------------------------------------------------------------
  logic w_load_use;
  logic w_mispredict;
  logic w_ret_d;
  logic w_f_stall;
  logic w_d_stall;
  logic w_d_bubble;
  logic w_e_bubble;
  logic w_ret_start;
  logic w_stall_evt;
  logic w_bubble_evt;

  // A destination of 0xF means "no register", so it must never match a
  // source that is also 0xF.
  assign w_load_use   = ((Eicode == C_ICODE_MRMOVQ) || (Eicode == C_ICODE_POPQ)) &&
                        (EdstM != C_REG_NONE) &&
                        ((EdstM == dsrcA) || (EdstM == dsrcB));
  assign w_mispredict = (Eicode == C_ICODE_JXX) && !ecnd;
  assign w_ret_d      = (Dicode == C_ICODE_RET);

  always_comb begin
    w_f_stall    = 1'b0;
    w_d_stall    = 1'b0;
    w_d_bubble   = 1'b0;
    w_e_bubble   = 1'b0;
    w_ret_start  = 1'b0;
    w_stall_evt  = 1'b0;
    w_bubble_evt = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_mispredict) begin
          // Squashes both wrong-path instructions; a ret sitting in D is
          // discarded with them, so no drain is started.
          w_d_bubble   = 1'b1;
          w_e_bubble   = 1'b1;
          w_bubble_evt = 1'b1;
        end else if (w_load_use) begin
          // D is held, so a ret in D gets another look next cycle.
          w_f_stall   = 1'b1;
          w_d_stall   = 1'b1;
          w_e_bubble  = 1'b1;
          w_stall_evt = 1'b1;
        end else if (w_ret_d) begin
          w_f_stall    = 1'b1;
          w_d_bubble   = 1'b1;
          w_ret_start  = 1'b1;
          w_bubble_evt = 1'b1;
        end
      end
      S_RET_WAIT: begin
        // Only bubbles occupy E here, so no other hazard can appear.
        w_f_stall    = 1'b1;
        w_d_bubble   = 1'b1;
        w_bubble_evt = 1'b1;
      end
      S_HALTED: begin
        w_f_stall = 1'b1;
        w_d_stall = 1'b1;
      end
      default: begin
        w_f_stall = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Control state machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_RUN;
      r_ret_cnt <= 2'd0;
    end else if (Wicode == C_ICODE_HALT) begin
      // A retired halt wins over everything, from any state.
      r_state <= S_HALTED;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_ret_start && (RET_BUBBLES > 1)) begin
            r_state   <= S_RET_WAIT;
            r_ret_cnt <= C_RET_LOAD;
          end
        end
        S_RET_WAIT: begin
          r_ret_cnt <= r_ret_cnt - 2'd1;
          if (r_ret_cnt <= 2'd1) begin
            r_state <= S_RUN;
          end
        end
        S_HALTED: begin
          r_state <= S_HALTED;
        end
        default: begin
          r_state <= S_RUN;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Saturating performance counters. Events are only raised in RUN and
  // RET_WAIT, so both counters hold still once halted.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != C_CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_bubble_evt && (r_bubble_cnt != C_CNT_MAX)) begin
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. The controls are combinational from inputs, so they are gated
  // with rst_n to read 0 for the whole time reset is held.
  // --------------------------------------------------------------------------
  assign F_stall    = w_f_stall  & rst_n;
  assign D_stall    = w_d_stall  & rst_n;
  assign D_bubble   = w_d_bubble & rst_n;
  assign E_bubble   = w_e_bubble & rst_n;
  assign halted     = (r_state == S_HALTED)   & rst_n;
  assign ret_busy   = (r_state == S_RET_WAIT) & rst_n;
  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Self-checking bench for pipe_hazard_ctrl. Each stimulus cycle
//               pushes its hand-computed expected outputs into a scoreboard
//               queue; a monitor on the falling edge pops and compares.
//               Counters are instantiated narrow so saturation is reachable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int CW = 3;

  localparam logic [3:0] HLT = 4'h0;
  localparam logic [3:0] NOP = 4'h1;
  localparam logic [3:0] MR  = 4'h5;
  localparam logic [3:0] JXX = 4'h7;
  localparam logic [3:0] RET = 4'h9;
  localparam logic [3:0] POP = 4'hB;
  localparam logic [3:0] N   = 4'hF;

  // {F_stall, D_stall, D_bubble, E_bubble, halted, ret_busy}
  localparam logic [5:0] C0 = 6'b000000;
  localparam logic [5:0] LU = 6'b110100;
  localparam logic [5:0] MP = 6'b001100;
  localparam logic [5:0] RT = 6'b101000;
  localparam logic [5:0] RW = 6'b101001;
  localparam logic [5:0] HL = 6'b110010;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [3:0]    Dicode = NOP, dsrcA = N, dsrcB = N, Eicode = NOP, EdstM = N, Wicode = NOP;
  logic          ecnd = 1'b1;
  logic          F_stall, D_stall, D_bubble, E_bubble, halted, ret_busy;
  logic [CW-1:0] stall_cnt, bubble_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(CW), .RET_BUBBLES(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Dicode     (Dicode),
    .dsrcA      (dsrcA),
    .dsrcB      (dsrcB),
    .Eicode     (Eicode),
    .EdstM      (EdstM),
    .ecnd       (ecnd),
    .Wicode     (Wicode),
    .F_stall    (F_stall),
    .D_stall    (D_stall),
    .D_bubble   (D_bubble),
    .E_bubble   (E_bubble),
    .halted     (halted),
    .ret_busy   (ret_busy),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  typedef struct packed {
    logic [5:0]    ctl;
    logic [CW-1:0] sc;
    logic [CW-1:0] bc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;
  exp_t mon_e;
  exp_t mon_a;

  function automatic exp_t actual();
    exp_t a;
    a.ctl = {F_stall, D_stall, D_bubble, E_bubble, halted, ret_busy};
    a.sc  = stall_cnt;
    a.bc  = bubble_cnt;
    return a;
  endfunction

  // Monitor: one scoreboard entry per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      mon_a = actual();
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL cycle%0d ctl/cnt: ctl act=%b exp=%b stall_cnt act=%0d exp=%0d bubble_cnt act=%0d exp=%0d",
                 cyc_no, mon_a.ctl, mon_e.ctl, mon_a.sc, mon_e.sc, mon_a.bc, mon_e.bc);
      end
      cyc_no++;
    end
  end

  // Drive one cycle of inputs just after the rising edge and queue the
  // outputs expected for that cycle.
  task automatic cyc(input logic r, input logic [3:0] di, input logic [3:0] sa,
                     input logic [3:0] sb, input logic [3:0] ei, input logic [3:0] ed,
                     input logic ec, input logic [3:0] wi,
                     input logic [5:0] ctl, input int sc, input int bc);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n  = r;
    Dicode = di;
    dsrcA  = sa;
    dsrcB  = sb;
    Eicode = ei;
    EdstM  = ed;
    ecnd   = ec;
    Wicode = wi;
    e.ctl  = ctl;
    e.sc   = CW'(sc);
    e.bc   = CW'(bc);
    sb_q.push_back(e);
  endtask

  task automatic nop_cyc(input logic [5:0] ctl, input int sc, input int bc);
    cyc(1'b1, NOP, N, N, NOP, N, 1'b1, NOP, ctl, sc, bc);
  endtask

  task automatic chk_now(input string nm, input exp_t e);
    exp_t a;
    a = actual();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: ctl act=%b exp=%b stall_cnt act=%0d exp=%0d bubble_cnt act=%0d exp=%0d",
               nm, a.ctl, e.ctl, a.sc, e.sc, a.bc, e.bc);
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;

    // Reset held with load-use inputs present: everything reads 0.
    cyc(1'b0, NOP, N, 4'd3, MR, 4'd3, 1'b1, NOP, C0, 0, 0);
    for (int i = 0; i < 5; i++) nop_cyc(C0, 0, 0);

    // Load-use on dsrcB, then a 0xF/0xF "match" that must not stall.
    cyc(1'b1, NOP, N, 4'd3, MR, 4'd3, 1'b1, NOP, LU, 0, 0);
    cyc(1'b1, NOP, N, N,    MR, N,    1'b1, NOP, C0, 1, 0);
    nop_cyc(C0, 1, 0);

    // Ret drain: three cycles of F_stall/D_bubble, ret_busy on the last two.
    cyc(1'b1, RET, N, N, NOP, N, 1'b1, NOP, RT, 1, 0);
    nop_cyc(RW, 1, 1);
    nop_cyc(RW, 1, 2);
    nop_cyc(C0, 1, 3);

    // Mispredict squashes a ret in D; a taken jump is not a mispredict.
    cyc(1'b1, RET, N, N, JXX, N, 1'b0, NOP, MP, 1, 3);
    nop_cyc(C0, 1, 4);
    cyc(1'b1, NOP, N, N, JXX, N, 1'b1, NOP, C0, 1, 4);

    // Load-use (popq on dsrcA) beats a ret, then the held ret drains.
    // Execute inputs in RET_WAIT are ignored; halt retires on the last drain cycle.
    cyc(1'b1, RET, 4'd4, N, POP, 4'd4, 1'b1, NOP, LU, 1, 4);
    cyc(1'b1, RET, N,    N, NOP, N,    1'b1, NOP, RT, 2, 4);
    cyc(1'b1, NOP, N,    N, JXX, N,    1'b0, NOP, RW, 2, 5);
    cyc(1'b1, NOP, N,    N, NOP, N,    1'b1, HLT, RW, 2, 6);

    // Halted: hazards ignored, counters frozen.
    cyc(1'b1, NOP, 4'd3, N, MR,  4'd3, 1'b1, NOP, HL, 2, 7);
    cyc(1'b1, NOP, N,    N, JXX, N,    1'b0, NOP, HL, 2, 7);

    // Asynchronous reset pulse mid-cycle while halted.
    nop_cyc(C0, 0, 0);
    #1 chk_now("halted_before_reset", '{ctl: HL, sc: CW'(2), bc: CW'(7)});
    #1 rst_n = 1'b0;
    #1 chk_now("async_reset_immediate", '{ctl: C0, sc: CW'(0), bc: CW'(0)});
    nop_cyc(C0, 0, 0);

    // Stall counter saturation at all-ones.
    for (int i = 0; i < 9; i++)
      cyc(1'b1, NOP, N, 4'd3, MR, 4'd3, 1'b1, NOP, LU, (i > 7) ? 7 : i, 0);
    nop_cyc(C0, 7, 0);

    // Bubble counter saturation via repeated mispredicts.
    for (int i = 0; i < 9; i++)
      cyc(1'b1, NOP, N, N, JXX, N, 1'b0, NOP, MP, 7, (i > 7) ? 7 : i);
    nop_cyc(C0, 7, 7);

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: pending act=%0d exp=0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline control unit for the five-stage Y86 pipeline (F, D, E, M, W).
- Sits beside the decode/forwarding block. Watches decode, execute and writeback stage state.
- Issues stall and bubble controls to the F, D and E pipeline registers.
- Sequences the three-cycle ret drain with an internal counter, latches processor halt, and keeps saturating hazard performance counters.

Parameters:
- CNT_W, 16, width of each performance counter.
- RET_BUBBLES, 3, number of D-bubble cycles inserted after a ret leaves decode.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge
- rst_n  in  1  reset; asynchronous assert, active-low
- Dicode  in  4  icode of the instruction in decode
- dsrcA  in  4  decode source A register ID (0xF = none)
- dsrcB  in  4  decode source B register ID (0xF = none)
- Eicode  in  4  icode in execute
- EdstM  in  4  execute-stage dstM (0xF = none)
- ecnd  in  1  condition result computed in execute
- Wicode  in  4  icode in writeback
- F_stall  out  1  hold the fetch PC register
- D_stall  out  1  hold the decode pipeline register
- D_bubble  out  1  load a nop into the decode register
- E_bubble  out  1  load a nop into the execute register
- halted  out  1  processor has retired a halt
- ret_busy  out  1  ret drain in progress
- stall_cnt  out  CNT_W  cycles lost to load-use stalls
- bubble_cnt  out  CNT_W  cycles lost to ret drains and mispredicts

Behaviour:
- Icodes: HALT=0, JXX=7, MRMOVQ=5, RET=9, POPQ=0xB. Register ID 0xF means "none" and never matches.
- States: RUN, RET_WAIT, HALTED. Internal ret_cnt is 2 bits.
- All control outputs are combinational from current state and inputs. State and counters update on posedge clk.
- Reset (rst_n=0, asynchronous):
  - state=RUN, ret_cnt=0, stall_cnt=0, bubble_cnt=0.
  - All control outputs, halted and ret_busy read 0 while reset is held.
- Event definitions in RUN:
  - load_use = (Eicode==MRMOVQ or Eicode==POPQ) and EdstM!=0xF and (EdstM==dsrcA or EdstM==dsrcB).
  - mispredict = Eicode==JXX and ecnd==0.
  - ret_d = Dicode==RET.
- Priority in RUN (one action per cycle):
  - If mispredict: D_bubble=1, E_bubble=1, F_stall=0. A ret in D is squashed, so ret_cnt is not loaded. bubble_cnt increments.
  - Else if load_use: F_stall=1, D_stall=1, E_bubble=1. A ret in D is held and re-evaluated next cycle. stall_cnt increments.
  - Else if ret_d: F_stall=1, D_bubble=1. Next state is RET_WAIT with ret_cnt=RET_BUBBLES-1. bubble_cnt increments.
  - Else: all controls are 0.
- RET_WAIT:
  - F_stall=1, D_bubble=1, ret_busy=1. bubble_cnt increments each cycle.
  - ret_cnt decrements each cycle. When ret_cnt==1 at the clock edge, next state is RUN.
  - Result: a ret produces exactly RET_BUBBLES consecutive cycles of F_stall/D_bubble, counting its own RUN cycle.
  - load_use and mispredict cannot arise here, because only bubbles occupy E. Inputs are ignored except Wicode.
- HALTED:
  - Entered from any state on the posedge where Wicode==HALT.
  - Outputs: halted=1, F_stall=1, D_stall=1, D_bubble=0, E_bubble=0.
  - Counters freeze. The block leaves HALTED only on reset.
- D_stall and D_bubble are never both 1 in the same cycle.
- Counters saturate at all-ones and do not wrap.
- Reset asserted mid-RET_WAIT or in HALTED returns to RUN immediately and clears the counters.

Test Plan:
- Reset, then Dicode=NOP, Eicode=NOP for 5 cycles -> all controls 0, stall_cnt=0, bubble_cnt=0, halted=0.
- Eicode=MRMOVQ, EdstM=3, dsrcB=3 for 1 cycle -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; stall_cnt=1. Repeat with EdstM=0xF, dsrcA=0xF -> no stall.
- Dicode=RET for 1 cycle, then NOPs -> F_stall=D_bubble=1 for exactly 3 cycles; ret_busy=1 for cycles 2-3; bubble_cnt=3; state back to RUN.
- Eicode=JXX, ecnd=0, same cycle Dicode=RET -> D_bubble=1, E_bubble=1, F_stall=0; next cycle ret_busy=0; bubble_cnt=1.
- Eicode=POPQ, EdstM=4, dsrcA=4, Dicode=RET -> load-use wins (D_stall=1, E_bubble=1). Next cycle with Eicode=NOP -> ret drain starts for 3 cycles.
- Wicode=HALT during RET_WAIT -> halted=1, F_stall=D_stall=1, counters frozen. Pulse rst_n low asynchronously mid-cycle -> outputs 0 immediately, counters 0.
